// File: rtl/elevator_request_scheduler.sv
// Elevator request scheduler: collects floor calls into a pending bitmap, picks the
// next target with a SCAN sweep, hands it to the controller and retires it on arrival.
// A door dwell follows each stop; dispatch is held off while weight/door alerts are up.
module elevator_request_scheduler #(
   parameter int unsigned NUM_FLOORS   = 16,
   parameter int unsigned FLOOR_W      = 4,
   parameter int unsigned DWELL_CYCLES = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  call_valid,
   input  logic [FLOOR_W-1:0]    call_floor,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  complete,
   input  logic                  weight_alert,
   input  logic                  door_alert,
   output logic [FLOOR_W-1:0]    request_floor,
   output logic                  request_valid,
   output logic                  sweep_up,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [4:0]            pending_count,
   output logic                  call_err
);

   localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DwellW-1:0] DwellLoad = DwellW'(DWELL_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StWaitDone,
      StDwell,
      StHold
   } state_e;

   state_e                  state_q, state_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic [4:0]              count_q, count_d;
   logic [FLOOR_W-1:0]      req_floor_q, req_floor_d;
   logic                    req_valid_q, req_valid_d;
   logic                    sweep_q, sweep_d;
   logic                    err_q, err_d;
   logic [DwellW-1:0]       dwell_q, dwell_d;

   logic                    call_ok;
   logic                    retire;
   logic                    alert;
   logic                    any_pending;
   logic                    at_cur;
   logic                    found_up;
   logic                    found_dn;
   logic [FLOOR_W-1:0]      up_floor;
   logic [FLOOR_W-1:0]      dn_floor;

   assign call_ok     = call_valid && (int'(call_floor) < int'(NUM_FLOORS));
   assign retire      = (state_q == StWaitDone) && complete && (cur_floor == req_floor_q);
   assign alert       = weight_alert || door_alert;
   assign any_pending = |pending_q;

   // Nearest pending floor above and below the cabin, plus a hit at the cabin itself.
   always_comb begin
      at_cur   = 1'b0;
      found_up = 1'b0;
      found_dn = 1'b0;
      up_floor = '0;
      dn_floor = '0;
      // Descending scan: last hit is the lowest floor above the cabin.
      for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
         if (pending_q[i] && (i > int'(cur_floor))) begin
            found_up = 1'b1;
            up_floor = FLOOR_W'(i);
         end
      end
      // Ascending scan: last hit is the highest floor below the cabin.
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         if (pending_q[i] && (i < int'(cur_floor))) begin
            found_dn = 1'b1;
            dn_floor = FLOOR_W'(i);
         end
         if (pending_q[i] && (i == int'(cur_floor))) begin
            at_cur = 1'b1;
         end
      end
   end

   // Pending bitmap update: capture in-range calls, retire wins over a same-cycle call.
   always_comb begin
      pending_d = pending_q;
      err_d     = call_valid && !call_ok;
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         if (call_ok && (int'(call_floor) == i)) begin
            pending_d[i] = 1'b1;
         end
         if (retire && (int'(req_floor_q) == i)) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   // Population count of the next bitmap so the registered count tracks pending exactly.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         count_d = count_d + 5'(pending_d[i]);
      end
   end

   // Dispatch FSM next-state and registered outputs.
   always_comb begin
      state_d     = state_q;
      req_floor_d = req_floor_q;
      req_valid_d = req_valid_q;
      sweep_d     = sweep_q;
      dwell_d     = dwell_q;
      unique case (state_q)
         StIdle: begin
            if (any_pending) state_d = StSelect;
         end
         StSelect: begin
            if (alert) begin
               state_d = StHold;
            end else if (!any_pending) begin
               state_d = StIdle;
            end else begin
               state_d     = StWaitDone;
               req_valid_d = 1'b1;
               if (at_cur) begin
                  req_floor_d = cur_floor;
               end else if (sweep_q) begin
                  if (found_up) begin
                     req_floor_d = up_floor;
                  end else begin
                     sweep_d     = 1'b0;
                     req_floor_d = dn_floor;
                  end
               end else begin
                  if (found_dn) begin
                     req_floor_d = dn_floor;
                  end else begin
                     sweep_d     = 1'b1;
                     req_floor_d = up_floor;
                  end
               end
            end
         end
         StWaitDone: begin
            if (retire) begin
               req_valid_d = 1'b0;
               dwell_d     = DwellLoad;
               state_d     = StDwell;
            end
         end
         StDwell: begin
            if (dwell_q == '0) begin
               if (alert)            state_d = StHold;
               else if (any_pending) state_d = StSelect;
               else                  state_d = StIdle;
            end else begin
               dwell_d = dwell_q - 1'b1;
            end
         end
         StHold: begin
            req_valid_d = 1'b0;
            if (!alert) state_d = any_pending ? StSelect : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset takes effect immediately, without a clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         pending_q   <= '0;
         count_q     <= '0;
         req_floor_q <= '0;
         req_valid_q <= 1'b0;
         sweep_q     <= 1'b1;
         err_q       <= 1'b0;
         dwell_q     <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         count_q     <= count_d;
         req_floor_q <= req_floor_d;
         req_valid_q <= req_valid_d;
         sweep_q     <= sweep_d;
         err_q       <= err_d;
         dwell_q     <= dwell_d;
      end
   end

   assign request_floor = req_floor_q;
   assign request_valid = req_valid_q;
   assign sweep_up      = sweep_q;
   assign pending       = pending_q;
   assign pending_count = count_q;
   assign call_err      = err_q;

endmodule
